// File: rtl/pad_scanner_if.sv
// Pad-side bus: shared latch/clock strobes and one serial return line per pad.
interface pad_scanner_if #(
  parameter int unsigned NUM_PADS = 1
);
  logic [NUM_PADS-1:0] serial_data;
  logic                data_latch;
  logic                data_clock;

  // Scanner drives the strobes and reads the pads' serial lines.
  modport master (
    input  serial_data,
    output data_latch,
    output data_clock
  );

  // Pads (or a pad model) answer on serial_data.
  modport slave (
    output serial_data,
    input  data_latch,
    input  data_clock
  );
endinterface

// File: rtl/pad_scanner.sv
// Scans 1..4 SNES-style serial pads on a shared latch/clock pair, publishes
// their raw button words (1 = released) and raises a KEYCNT-style keypad
// interrupt on pad 0.
module pad_scanner #(
  parameter int unsigned NUM_PADS    = 1,
  parameter int unsigned PAD_BITS    = 16,
  parameter int unsigned HALF_PERIOD = 100,
  parameter int unsigned SCAN_GAP    = 262144
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         enable,
  pad_scanner_if.master                pad,
  input  logic [PAD_BITS-1:0]          key_mask,
  input  logic                         key_irq_en,
  input  logic                         key_irq_and,
  output logic [NUM_PADS*PAD_BITS-1:0] buttons,
  output logic                         busy,
  output logic                         scan_done,
  output logic                         key_irq
);

  localparam int unsigned CNT_MAX = (SCAN_GAP > 2*HALF_PERIOD) ? SCAN_GAP : 2*HALF_PERIOD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (PAD_BITS > 1) ? $clog2(PAD_BITS) : 1;

  localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(SCAN_GAP - 1);
  localparam logic [CNT_W-1:0] LATCH_M1 = CNT_W'(2*HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAD_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    CLK_HI,
    CLK_LO,
    DONE
  } state_e;

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [NUM_PADS-1:0]                sync1_q, sync1_d;
  logic [NUM_PADS-1:0]                sync2_q, sync2_d;
  logic [NUM_PADS-1:0][PAD_BITS-1:0]  shadow_q, shadow_d;
  logic [NUM_PADS*PAD_BITS-1:0]       buttons_q, buttons_d;
  logic                               data_latch_q, data_latch_d;
  logic                               data_clock_q, data_clock_d;
  logic                               busy_q, busy_d;
  logic                               scan_done_q, scan_done_d;
  logic                               key_irq_q, key_irq_d;

  // KEYCNT condition: AND mode needs every selected key down, OR mode any.
  function automatic logic irq_cond(input logic [PAD_BITS-1:0] word,
                                    input logic [PAD_BITS-1:0] mask,
                                    input logic                and_mode);
    logic [PAD_BITS-1:0] pressed;
    pressed = ~word & mask;
    return and_mode ? ((mask != '0) && (pressed == mask)) : (|pressed);
  endfunction

  // Next-state logic: one counter times every state; IDLE counts enabled
  // clocks upward (cleared while disabled), scan states count down to 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sync1_d     = pad.serial_data;
    sync2_d     = sync1_q;
    shadow_d    = shadow_q;
    buttons_d   = buttons_q;
    scan_done_d = 1'b0;
    key_irq_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!enable) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_M1) begin
          state_d = LATCH;
          cnt_d   = LATCH_M1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = HALF_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          for (int unsigned p = 0; p < NUM_PADS; p++) begin
            shadow_d[p][0] = sync2_q[p];
          end
          idx_d = IDX_W'(1);
          cnt_d = HALF_M1;
          state_d = (PAD_BITS == 1) ? DONE : CLK_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CLK_HI: begin
        if (cnt_q == '0) begin
          state_d = CLK_LO;
          cnt_d   = HALF_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CLK_LO: begin
        if (cnt_q == '0) begin
          for (int unsigned p = 0; p < NUM_PADS; p++) begin
            shadow_d[p][idx_q] = sync2_q[p];
          end
          cnt_d = HALF_M1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = CLK_HI;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        buttons_d   = shadow_q;
        scan_done_d = 1'b1;
        key_irq_d   = key_irq_en
                    && irq_cond(shadow_q[0], key_mask, key_irq_and)
                    && !irq_cond(buttons_q[PAD_BITS-1:0], key_mask, key_irq_and);
        state_d     = IDLE;
        cnt_d       = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Strobes decode the next state so the registered copies line up with state_q.
    data_latch_d = (state_d == LATCH);
    data_clock_d = (state_d == CLK_HI);
    busy_d       = (state_d != IDLE);
  end

  // State and output registers; reset discards any partial scan.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      sync1_q      <= '1;
      sync2_q      <= '1;
      shadow_q     <= '1;
      buttons_q    <= '1;
      data_latch_q <= 1'b0;
      data_clock_q <= 1'b0;
      busy_q       <= 1'b0;
      scan_done_q  <= 1'b0;
      key_irq_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      shadow_q     <= shadow_d;
      buttons_q    <= buttons_d;
      data_latch_q <= data_latch_d;
      data_clock_q <= data_clock_d;
      busy_q       <= busy_d;
      scan_done_q  <= scan_done_d;
      key_irq_q    <= key_irq_d;
    end
  end

  assign pad.data_latch = data_latch_q;
  assign pad.data_clock = data_clock_q;
  assign buttons        = buttons_q;
  assign busy           = busy_q;
  assign scan_done      = scan_done_q;
  assign key_irq        = key_irq_q;

endmodule

// File: tb/tb_pad_scanner.sv
// Bench for pad_scanner: shift-register pad model, timeline-based reference
// model checked every cycle, plus directed literal expectations.
module tb_pad_scanner;
  localparam int unsigned NP  = 2;
  localparam int unsigned PB  = 12;
  localparam int unsigned HP  = 4;
  localparam int unsigned GAP = 10;
  localparam int unsigned SCAN_LEN = 3*HP + 2*HP*(PB-1) + 1;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          enable = 1'b0;
  logic [PB-1:0] key_mask = '0;
  logic          key_irq_en = 1'b0;
  logic          key_irq_and = 1'b0;
  logic [NP*PB-1:0] buttons;
  logic          busy, scan_done, key_irq;

  logic [PB-1:0] word [NP];
  logic [PB-1:0] sh [NP];
  logic          clk_prev = 1'b0;

  int unsigned checks = 0;
  int unsigned passes = 0;
  bit          cmp_on = 1'b0;

  pad_scanner_if #(.NUM_PADS(NP)) pad_bus ();

  pad_scanner #(
    .NUM_PADS(NP), .PAD_BITS(PB), .HALF_PERIOD(HP), .SCAN_GAP(GAP)
  ) dut (
    .clk(clk), .rst_b(rst_b), .enable(enable), .pad(pad_bus),
    .key_mask(key_mask), .key_irq_en(key_irq_en), .key_irq_and(key_irq_and),
    .buttons(buttons), .busy(busy), .scan_done(scan_done), .key_irq(key_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit cond(input logic [PB-1:0] w, input logic [PB-1:0] m, input bit and_mode);
    logic [PB-1:0] pr;
    pr = ~w & m;
    return and_mode ? ((m != '0) && (pr == m)) : (|pr);
  endfunction

  // Pad model: loads its word while latched, shifts toward bit 0 on each clock rise.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (pad_bus.data_latch) sh[p] = word[p];
      else if (pad_bus.data_clock && !clk_prev) sh[p] = {1'b1, sh[p][PB-1:1]};
      pad_bus.serial_data[p] = sh[p][0];
    end
    clk_prev = pad_bus.data_clock;
  end

  // Reference model: position within the scan timeline (0 = idle).
  int unsigned      m_pos, m_idle;
  logic [NP*PB-1:0] m_buttons, m_snap;
  logic             m_done, m_irq;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_pos <= 0; m_idle <= 0; m_buttons <= '1; m_snap <= '1;
      m_done <= 1'b0; m_irq <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_irq  <= 1'b0;
      if (m_pos == 0) begin
        if (!enable) m_idle <= 0;
        else if (m_idle + 1 == GAP) begin
          m_idle <= 0; m_pos <= 1; m_snap <= {word[1], word[0]};
        end else m_idle <= m_idle + 1;
      end else if (m_pos == SCAN_LEN) begin
        m_pos <= 0; m_buttons <= m_snap; m_done <= 1'b1;
        m_irq <= key_irq_en && cond(m_snap[PB-1:0], key_mask, key_irq_and)
                 && !cond(m_buttons[PB-1:0], key_mask, key_irq_and);
      end else m_pos <= m_pos + 1;
    end
  end

  function automatic bit exp_clock(input int unsigned p);
    if (p <= 3*HP || p >= SCAN_LEN) return 1'b0;
    return ((p - 3*HP - 1) % (2*HP)) < HP;
  endfunction

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_on) begin
      check("m_latch", pad_bus.data_latch, (m_pos >= 1 && m_pos <= 2*HP));
      check("m_clock", pad_bus.data_clock, exp_clock(m_pos));
      check("m_busy", busy, (m_pos != 0));
      check("m_done", scan_done, m_done);
      check("m_irq", key_irq, m_irq);
      check("m_buttons", buttons, m_buttons);
    end
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (scan_done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++;
      $display("FAIL done_timeout: scan_done absent for 400 cycles, required within that bound");
    end
  endtask

  task automatic latch_latency(input string name);
    int n;
    n = 0;
    while (!pad_bus.data_latch && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check(name, n, GAP);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int nb, rises, highs, seen, falls;
    logic prevc;
    pad_bus.serial_data = '1;
    for (int p = 0; p < NP; p++) begin word[p] = '1; sh[p] = '1; end

    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    cmp_on = 1'b1;
    @(posedge clk); #1;
    check("rst_buttons", buttons, 24'hFFFFFF);
    check("rst_busy", busy, 1'b0);
    check("rst_latch", pad_bus.data_latch, 1'b0);
    check("rst_clock", pad_bus.data_clock, 1'b0);
    check("rst_done", scan_done, 1'b0);
    check("rst_irq", key_irq, 1'b0);

    // First scan: timing and data
    @(negedge clk);
    word[0] = 12'hA5C; word[1] = 12'h3F0; enable = 1'b1;
    latch_latency("first_latch_delay");
    nb = 1; rises = 0; highs = 0; prevc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
      nb++;
      if (pad_bus.data_clock) highs++;
      if (pad_bus.data_clock && !prevc) rises++;
      prevc = pad_bus.data_clock;
    end
    check("busy_len", nb, 101);
    check("clock_pulses", rises, 11);
    check("clock_high_cycles", highs, 44);
    check("done_after_busy", scan_done, 1'b1);
    check("buttons_first", buttons, 24'h3F0A5C);
    @(posedge clk); #1;
    check("done_single_pulse", scan_done, 1'b0);
    wait_done(ok);
    check("buttons_repeat", buttons, 24'h3F0A5C);

    @(negedge clk); word[0] = 12'hFFF; word[1] = 12'hFFF;
    wait_done(ok);

    // OR mode
    @(negedge clk); key_mask = 12'h001; key_irq_en = 1'b1; key_irq_and = 1'b0; word[0] = 12'hFFE;
    wait_done(ok); check("or_first_press", key_irq, 1'b1);
    wait_done(ok); check("or_held", key_irq, 1'b0);
    @(negedge clk); word[0] = 12'hFFF;
    wait_done(ok); check("or_release", key_irq, 1'b0);
    @(negedge clk); word[0] = 12'hFFE;
    wait_done(ok); check("or_repress", key_irq, 1'b1);

    // AND mode
    @(negedge clk); key_mask = 12'h003; key_irq_and = 1'b1; word[0] = 12'hFFF;
    wait_done(ok);
    @(negedge clk); word[0] = 12'hFFE;
    wait_done(ok); check("and_one_key", key_irq, 1'b0);
    @(negedge clk); word[0] = 12'hFFC;
    wait_done(ok); check("and_both_keys", key_irq, 1'b1);
    @(negedge clk); key_mask = 12'h000; word[0] = 12'hFFF;
    wait_done(ok);
    @(negedge clk); word[0] = 12'h000;
    wait_done(ok); check("and_mask_zero", key_irq, 1'b0);

    // Randomized scans
    for (int s = 0; s < 25; s++) begin
      @(negedge clk);
      word[0] = PB'($urandom) | PB'($urandom);
      word[1] = PB'($urandom);
      key_mask = ($urandom_range(0, 1) == 1) ? PB'($urandom_range(0, 7)) : PB'($urandom);
      key_irq_and = 1'($urandom_range(0, 1));
      key_irq_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 15)) @(negedge clk);
        enable = 1'b1;
      end
      wait_done(ok);
    end

    // Enable dropped during LATCH
    @(negedge clk); key_irq_en = 1'b0;
    latch_latency("latch_before_drop");
    @(negedge clk); enable = 1'b0;
    wait_done(ok);
    check("drop_scan_completes", ok, 1'b1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (pad_bus.data_latch) seen++;
    end
    check("no_latch_disabled", seen, 0);
    @(negedge clk); enable = 1'b1; word[0] = 12'h000;
    latch_latency("relatch_delay");

    // Reset in the middle of CLK_LO
    falls = 0; prevc = pad_bus.data_clock;
    for (int i = 0; i < 200 && falls < 3; i++) begin
      @(posedge clk); #1;
      if (!pad_bus.data_clock && prevc) falls++;
      prevc = pad_bus.data_clock;
    end
    check("clk_lo_reached", falls, 3);
    @(negedge clk); rst_b = 1'b0; #1;
    check("arst_buttons", buttons, 24'hFFFFFF);
    check("arst_busy", busy, 1'b0);
    check("arst_latch", pad_bus.data_latch, 1'b0);
    check("arst_clock", pad_bus.data_clock, 1'b0);
    check("arst_done", scan_done, 1'b0);
    check("arst_irq", key_irq, 1'b0);
    @(negedge clk); rst_b = 1'b1;
    seen = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (scan_done) begin ok = 1'b1; break; end
      if (buttons !== 24'hFFFFFF) seen++;
    end
    check("post_reset_scan", ok, 1'b1);
    check("buttons_held_ones", seen, 0);
    check("post_reset_buttons", buttons, {word[1], 12'h000});

    @(negedge clk);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
